// File: rtl/down_timer.sv
// down_timer: loadable down counter with one-shot or auto-reload operation,
// a one-cycle terminal-count pulse and a sticky one-shot completion flag.
module down_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] reload;

    assign busy = (state == RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            reload <= '0;
            tc     <= 1'b0;
            done   <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (load) begin
                count  <= load_val;
                reload <= load_val;
                done   <= 1'b0;
                if (stop || load_val == '0)
                    state <= IDLE;
            end else if (stop) begin
                state <= IDLE;
            end else if (state == IDLE) begin
                if (start && count != '0) begin
                    state <= RUN;
                    done  <= 1'b0;
                end
            end else if (count == '0) begin
                // only reachable after an auto-reload terminal count
                count <= reload;
            end else begin
                count <= count - WIDTH'(1);
                if (count == WIDTH'(1)) begin
                    tc <= 1'b1;
                    if (!auto_reload) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: directed scenarios plus randomized traffic checked against
// a behavioural model of the timer rules.
module tb_down_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0, start = 1'b0, stop = 1'b0, auto_reload = 1'b0;
    logic [3:0] load_val = '0;
    logic [3:0] count;
    logic       busy, tc, done;

    int errors = 0;
    int checks = 0;

    logic [3:0] m_cnt, m_rel;
    logic       m_run, m_tc, m_done;

    down_timer #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset), .load(load), .load_val(load_val),
        .start(start), .stop(stop), .auto_reload(auto_reload),
        .count(count), .busy(busy), .tc(tc), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_rel = 0; m_run = 0; m_tc = 0; m_done = 0;
    endtask

    task automatic model_edge(input logic l, input logic [3:0] lv, input logic s, input logic p, input logic ar);
        m_tc = 0;
        if (l) begin
            m_cnt = lv; m_rel = lv; m_done = 0;
            if (p || lv == 0) m_run = 0;
        end else if (p) begin
            m_run = 0;
        end else if (!m_run) begin
            if (s && m_cnt != 0) begin m_run = 1; m_done = 0; end
        end else if (m_cnt == 0) begin
            m_cnt = m_rel;
        end else begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                m_tc = 1;
                if (!ar) begin m_run = 0; m_done = 1; end
            end
        end
    endtask

    task automatic step(input logic l, input logic [3:0] lv, input logic s, input logic p, input logic ar);
        load = l; load_val = lv; start = s; stop = p; auto_reload = ar;
        @(posedge clk);
        model_edge(l, lv, s, p, ar);
        #1;
        check("count", 32'(count), 32'(m_cnt));
        check("busy", 32'(busy), 32'(m_run));
        check("tc", 32'(tc), 32'(m_tc));
        check("done", 32'(done), 32'(m_done));
    endtask

    task automatic idle_step(input logic ar);
        step(1'b0, 4'd0, 1'b0, 1'b0, ar);
    endtask

    initial begin
        int n, ntc;
        logic ar;
        model_reset();
        #1;
        check("reset_count", 32'(count), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_tc", 32'(tc), 0);
        check("reset_done", 32'(done), 0);
        @(negedge clk);
        reset = 1'b0;

        // one-shot
        step(1, 4'd3, 0, 0, 0);
        step(0, 4'd0, 1, 0, 0);
        check("os_start_cnt", 32'(count), 3);
        check("os_start_busy", 32'(busy), 1);
        repeat (3) idle_step(0);
        check("os_end_cnt", 32'(count), 0);
        check("os_end_tc", 32'(tc), 1);
        check("os_end_done", 32'(done), 1);
        check("os_end_busy", 32'(busy), 0);
        idle_step(0);
        check("os_tc_drop", 32'(tc), 0);
        check("os_done_sticky", 32'(done), 1);

        // auto-reload
        step(1, 4'd2, 0, 0, 1);
        check("ar_load_done_clr", 32'(done), 0);
        step(0, 4'd0, 1, 0, 1);
        for (int i = 0; i < 6; i++) begin
            idle_step(1);
            check("ar_cnt", 32'(count), (i % 3 == 0) ? 1 : (i % 3 == 1) ? 0 : 2);
            check("ar_tc", 32'(tc), (i % 3 == 1) ? 1 : 0);
            check("ar_busy", 32'(busy), 1);
            check("ar_done", 32'(done), 0);
        end
        step(0, 4'd0, 0, 1, 0);

        // pause and resume
        step(1, 4'd9, 0, 0, 0);
        step(0, 4'd0, 1, 0, 0);
        repeat (2) idle_step(0);
        step(0, 4'd0, 0, 1, 0);
        check("pause_cnt", 32'(count), 7);
        check("pause_busy", 32'(busy), 0);
        step(0, 4'd0, 1, 0, 0);
        ntc = 0;
        for (int i = 0; i < 10; i++) begin
            idle_step(0);
            ntc += int'(tc);
        end
        check("resume_cnt", 32'(count), 0);
        check("resume_tcs", 32'(ntc), 1);

        // full-scale load
        step(1, 4'd15, 0, 0, 0);
        step(0, 4'd0, 1, 0, 0);
        n = 1;
        while (!tc && n < 40) begin idle_step(0); n++; end
        check("max_edges", 32'(n), 16);

        // start with zero count
        step(0, 4'd0, 1, 0, 0);
        check("zero_start_busy", 32'(busy), 0);
        check("zero_start_tc", 32'(tc), 0);

        // load 0 while running
        step(1, 4'd5, 0, 0, 0);
        step(0, 4'd0, 1, 0, 0);
        idle_step(0);
        step(1, 4'd0, 0, 0, 0);
        check("run_load0_busy", 32'(busy), 0);
        check("run_load0_tc", 32'(tc), 0);
        check("run_load0_cnt", 32'(count), 0);

        // asynchronous reset mid-count
        step(1, 4'd5, 0, 0, 0);
        step(0, 4'd0, 1, 0, 0);
        repeat (2) idle_step(0);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("arst_cnt", 32'(count), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_tc", 32'(tc), 0);
        @(posedge clk);
        #1;
        check("arst_hold_cnt", 32'(count), 0);
        reset = 1'b0;
        step(1, 4'd4, 0, 0, 0);
        check("post_rst_load", 32'(count), 4);

        // randomized traffic
        ar = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(7) == 0) ar = ~ar;
            if ($urandom_range(199) == 0) begin
                #1 reset = 1'b1;
                #1;
                model_reset();
                check("rnd_arst_cnt", 32'(count), 0);
                check("rnd_arst_busy", 32'(busy), 0);
                #1 reset = 1'b0;
            end
            step($urandom_range(11) == 0, 4'($urandom_range(15)),
                 !m_run && $urandom_range(3) == 0, $urandom_range(19) == 0, ar);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/down_timer.md
DOWN_TIMER -- requirements
Module: down_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter/load width in bits (legal 2..16).
REQ-002 SHALL have port clk  input  1  counter clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port load  input  1  load load_val into count and reload register.
REQ-005 SHALL have port load_val  input  WIDTH  value captured on load.
REQ-006 SHALL have port start  input  1  begin or resume counting down.
REQ-007 SHALL have port stop  input  1  pause counting and hold count.
REQ-008 SHALL have port auto_reload  input  1  1 = reload and continue at zero; 0 = one-shot.
REQ-009 SHALL have port count  output  WIDTH  current registered count value.
REQ-010 SHALL have port busy  output  1  high while in state RUN.
REQ-011 SHALL have port tc  output  1  terminal-count pulse, one cycle.
REQ-012 SHALL have port done  output  1  sticky one-shot completion flag.

Function
REQ-013 SHALL implement states IDLE and RUN; busy = (state == RUN), registered.
REQ-014 SHALL keep an internal WIDTH-bit reload register written only by load.
REQ-015 Input priority per edge SHALL be: load > stop > start > decrement.
REQ-016 IDLE + load: count <= load_val, reload <= load_val, done <= 0; state stays IDLE.
REQ-017 IDLE + start (no load/stop), count != 0: state <= RUN, done <= 0; count unchanged on that edge.
REQ-018 IDLE + start with count == 0: ignored, state stays IDLE, no tc, done unchanged.
REQ-019 RUN, no control input: count <= count - 1 each edge; no wrap below 0.
REQ-020 RUN, count == 1 decrementing to 0: tc <= 1 on the same edge.
REQ-021 On that edge with auto_reload == 0: state <= IDLE, done <= 1.
REQ-022 On that edge with auto_reload == 1: state stays RUN.
REQ-023 RUN with count == 0 and auto_reload == 1: next edge count <= reload, tc <= 0.
REQ-024 Auto-reload period SHALL therefore be reload+1 cycles: sequence reload..1,0.
REQ-025 tc SHALL be high for exactly one cycle per terminal count, otherwise 0.
REQ-026 RUN + stop: state <= IDLE, count held, no tc, done unchanged.
REQ-027 Resume from IDLE via start continues from held count.
REQ-028 RUN + load, load_val != 0: count/reload <= load_val, stay RUN; decrement resumes next edge.
REQ-029 RUN + load, load_val == 0: count <= 0, state <= IDLE, no tc, done stays 0.
REQ-030 load + stop on the same edge: load applied, then state <= IDLE.
REQ-031 auto_reload SHALL be sampled only on the edge count reaches 0; changes elsewhere have no effect.
REQ-032 done SHALL stay high until the next load or accepted start.

Reset
REQ-033 reset high SHALL immediately, without clock, force state IDLE, count 0, reload 0, tc 0, done 0, busy 0.
REQ-034 reset SHALL override all inputs while high, including mid-count in RUN.
REQ-035 First edge after reset release SHALL act on inputs normally.

Verification (WIDTH = 4)
REQ-036 One-shot: load 3, then start, auto_reload 0 -> count 3,3,2,1,0 on successive edges; tc high one cycle with count 0; done 1; busy 0 after.
REQ-037 Auto-reload: load 2, start, auto_reload 1 -> count 2,1,0,2,1,0,...; tc every 3rd cycle, busy stays 1, done stays 0.
REQ-038 Pause: load 9, start, stop after 2 decrements -> count holds 7, busy 0; start -> 6,5,... to 0 with one tc.
REQ-039 Boundaries: load 15 -> 16 RUN cycles to tc; start with count 0 -> no busy, no tc; RUN load 0 -> IDLE, no tc.
REQ-040 Async reset: load 5, start, assert reset between edges after 2 decrements -> count 0, busy 0 before next edge; no tc.
